// File: rtl/fu_sched.sv
// rtl/fu_sched.sv - occupancy and completion controller for fixed-latency non-pipelined FUs
module fu_sched #(
    parameter int NUM_FU  = 2,
    parameter int LAT     = 4,
    parameter int TAG_W   = 6,
    parameter int BMASK_W = 4,
    localparam int CNT_W  = $clog2(LAT + 1),
    localparam int NR_W   = $clog2(NUM_FU + 1)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_FU-1:0]                 issue_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]      issue_tag,
    input  logic [NUM_FU-1:0][BMASK_W-1:0]    issue_bmask,
    input  logic [NUM_FU-1:0]                 cdb_gnt,
    input  logic                              squash_valid,
    input  logic [BMASK_W-1:0]                squash_bmask,
    input  logic                              resolve_valid,
    input  logic [BMASK_W-1:0]                resolve_bmask,
    output logic [NUM_FU-1:0]                 fu_ready,
    output logic [NR_W-1:0]                   num_ready,
    output logic [NUM_FU-1:0]                 cdb_req,
    output logic [NUM_FU-1:0][TAG_W-1:0]      cdb_tag,
    output logic [NUM_FU-1:0][BMASK_W-1:0]    cdb_bmask
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    state_t             r_state     [NUM_FU];
    state_t             w_state_nxt [NUM_FU];
    logic [CNT_W-1:0]   r_cnt       [NUM_FU];
    logic [CNT_W-1:0]   w_cnt_nxt   [NUM_FU];
    logic [TAG_W-1:0]   r_tag       [NUM_FU];
    logic [TAG_W-1:0]   w_tag_nxt   [NUM_FU];
    logic [BMASK_W-1:0] r_bmask     [NUM_FU];
    logic [BMASK_W-1:0] w_bmask_nxt [NUM_FU];

    logic [NUM_FU-1:0]  w_ready;
    logic [NUM_FU-1:0]  w_kill;
    logic [NUM_FU-1:0]  w_accept;
    logic [BMASK_W-1:0] w_res_clr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
                r_tag[i]   <= '0;
                r_bmask[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_tag[i]   <= w_tag_nxt[i];
                r_bmask[i] <= w_bmask_nxt[i];
            end
        end
    end

    always_comb begin
        w_res_clr = resolve_valid ? resolve_bmask : '0;
        w_ready   = '0;
        w_kill    = '0;
        w_accept  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_tag_nxt[i]   = r_tag[i];
            w_bmask_nxt[i] = r_bmask[i] & ~w_res_clr;

            // A granted DONE FU is free this same cycle so the selector can refill it.
            w_ready[i]  = (r_state[i] == S_IDLE) || ((r_state[i] == S_DONE) && cdb_gnt[i]);
            w_kill[i]   = squash_valid && (r_state[i] != S_IDLE) && |(r_bmask[i] & squash_bmask);
            w_accept[i] = issue_valid[i] && w_ready[i] &&
                          !(squash_valid && |(issue_bmask[i] & squash_bmask));

            if (w_accept[i]) begin
                w_tag_nxt[i]   = issue_tag[i];
                w_bmask_nxt[i] = issue_bmask[i] & ~w_res_clr;
                if (LAT == 1) begin
                    w_state_nxt[i] = S_DONE;
                    w_cnt_nxt[i]   = '0;
                end else begin
                    w_state_nxt[i] = S_BUSY;
                    w_cnt_nxt[i]   = CNT_INIT;
                end
            end else if (w_kill[i]) begin
                w_state_nxt[i] = S_IDLE;
                w_cnt_nxt[i]   = '0;
            end else begin
                case (r_state[i])
                    S_BUSY: begin
                        if (r_cnt[i] == CNT_W'(1)) begin
                            w_state_nxt[i] = S_DONE;
                            w_cnt_nxt[i]   = '0;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (cdb_gnt[i]) begin
                            w_state_nxt[i] = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = r_state[i];
                    end
                endcase
            end
        end
    end

    always_comb begin
        fu_ready  = w_ready;
        num_ready = '0;
        cdb_req   = '0;
        cdb_tag   = '0;
        cdb_bmask = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            num_ready    = num_ready + NR_W'(w_ready[i]);
            cdb_req[i]   = (r_state[i] == S_DONE);
            cdb_tag[i]   = r_tag[i];
            cdb_bmask[i] = r_bmask[i];
        end
    end

endmodule

// File: tb/tb_fu_sched.sv
// tb/tb_fu_sched.sv - directed and random checks of fu_sched at LAT=4 and LAT=1
module tb_fu_sched;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset;
    logic [1:0]           issue_valid;
    logic [1:0][5:0]      issue_tag;
    logic [1:0][3:0]      issue_bmask;
    logic [1:0]           cdb_gnt;
    logic                 squash_valid;
    logic [3:0]           squash_bmask;
    logic                 resolve_valid;
    logic [3:0]           resolve_bmask;

    logic [1:0]           o_ready [2];
    logic [1:0]           o_num   [2];
    logic [1:0]           o_req   [2];
    logic [1:0][5:0]      o_tag   [2];
    logic [1:0][3:0]      o_bm    [2];

    fu_sched #(.NUM_FU(2), .LAT(4), .TAG_W(6), .BMASK_W(4)) u_lat4 (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_bmask(issue_bmask),
        .cdb_gnt(cdb_gnt),
        .squash_valid(squash_valid), .squash_bmask(squash_bmask),
        .resolve_valid(resolve_valid), .resolve_bmask(resolve_bmask),
        .fu_ready(o_ready[0]), .num_ready(o_num[0]), .cdb_req(o_req[0]),
        .cdb_tag(o_tag[0]), .cdb_bmask(o_bm[0])
    );

    fu_sched #(.NUM_FU(2), .LAT(1), .TAG_W(6), .BMASK_W(4)) u_lat1 (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_bmask(issue_bmask),
        .cdb_gnt(cdb_gnt),
        .squash_valid(squash_valid), .squash_bmask(squash_bmask),
        .resolve_valid(resolve_valid), .resolve_bmask(resolve_bmask),
        .fu_ready(o_ready[1]), .num_ready(o_num[1]), .cdb_req(o_req[1]),
        .cdb_tag(o_tag[1]), .cdb_bmask(o_bm[1])
    );

    // Reference: each FU is an occupancy flag plus the edge number its result appears.
    bit         m_occ  [2][2];
    int         m_done [2][2];
    logic [5:0] m_tag  [2][2];
    logic [3:0] m_bm   [2][2];
    int         edges;
    int         n_vec;
    int         n_err;

    function automatic int lat_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic bit exp_req(int k, int i);
        return m_occ[k][i] && (edges >= m_done[k][i]);
    endfunction

    function automatic bit exp_ready(int k, int i);
        return !m_occ[k][i] || (exp_req(k, i) && cdb_gnt[i]);
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", name, obs, exp, edges);
        end
    endtask

    task automatic compare_all();
        logic [1:0] er;
        logic [1:0] eq;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                er[i] = exp_ready(k, i);
                eq[i] = exp_req(k, i);
            end
            check($sformatf("lat%0d_fu_ready", lat_of(k)), 32'(o_ready[k]), 32'(er));
            check($sformatf("lat%0d_num_ready", lat_of(k)), 32'(o_num[k]), 32'($countones(er)));
            check($sformatf("lat%0d_cdb_req", lat_of(k)), 32'(o_req[k]), 32'(eq));
            for (int i = 0; i < 2; i++) begin
                if (eq[i]) begin
                    check($sformatf("lat%0d_cdb_tag%0d", lat_of(k), i), 32'(o_tag[k][i]), 32'(m_tag[k][i]));
                    check($sformatf("lat%0d_cdb_bmask%0d", lat_of(k), i), 32'(o_bm[k][i]), 32'(m_bm[k][i]));
                end
            end
        end
        check("illegal_issue", 32'(issue_valid & ~o_ready[0]), 32'd0);
    endtask

    task automatic model_edge();
        logic [3:0] clr;
        bit rq;
        bit rdy;
        clr = resolve_valid ? resolve_bmask : 4'd0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                rq  = exp_req(k, i);
                rdy = exp_ready(k, i);
                if (!reset) begin
                    m_occ[k][i] = 1'b0;
                    m_tag[k][i] = '0;
                    m_bm[k][i]  = '0;
                end else if (issue_valid[i] && rdy &&
                             !(squash_valid && ((issue_bmask[i] & squash_bmask) != 4'd0))) begin
                    m_occ[k][i]  = 1'b1;
                    m_tag[k][i]  = issue_tag[i];
                    m_bm[k][i]   = issue_bmask[i] & ~clr;
                    m_done[k][i] = edges + lat_of(k);
                end else begin
                    if (m_occ[k][i] && squash_valid && ((m_bm[k][i] & squash_bmask) != 4'd0))
                        m_occ[k][i] = 1'b0;
                    else if (rq && cdb_gnt[i])
                        m_occ[k][i] = 1'b0;
                    m_bm[k][i] = m_bm[k][i] & ~clr;
                end
            end
        end
    endtask

    task automatic tick();
        #2;
        compare_all();
        @(posedge clock);
        model_edge();
        edges++;
        #1;
        issue_valid   = '0;
        cdb_gnt       = '0;
        squash_valid  = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic issue(input int i, input logic [5:0] tag, input logic [3:0] bm);
        issue_valid[i] = 1'b1;
        issue_tag[i]   = tag;
        issue_bmask[i] = bm;
    endtask

    initial begin
        n_vec = 0; n_err = 0; edges = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 2; i++) begin
                m_occ[k][i] = 1'b0; m_done[k][i] = 0; m_tag[k][i] = '0; m_bm[k][i] = '0;
            end
        reset = 1'b0;
        issue_valid = '0; issue_tag = '0; issue_bmask = '0; cdb_gnt = '0;
        squash_valid = 1'b0; squash_bmask = '0; resolve_valid = 1'b0; resolve_bmask = '0;
        @(posedge clock); #1;
        tick(); tick();
        reset = 1'b1;

        #2;
        check("rst_fu_ready", 32'(o_ready[0]), 32'h3);
        check("rst_num_ready", 32'(o_num[0]), 32'd2);
        check("rst_cdb_req", 32'(o_req[0]), 32'd0);
        check("rst_cdb_tag", 32'(o_tag[0]), 32'd0);
        check("rst_cdb_bmask", 32'(o_bm[0]), 32'd0);

        // Latency: issue FU0 tag 5, result appears LAT cycles later.
        issue(0, 6'd5, 4'd0);
        tick();
        #2;
        check("issue_fu_ready", 32'(o_ready[0]), 32'h2);
        check("lat1_req_next", 32'(o_req[1][0]), 32'd1);
        check("lat1_tag_next", 32'(o_tag[1][0]), 32'd5);
        tick(); tick();
        #2 check("lat4_req_early", 32'(o_req[0][0]), 32'd0);
        tick();
        #2;
        check("lat4_req_on_time", 32'(o_req[0][0]), 32'd1);
        check("lat4_tag_on_time", 32'(o_tag[0][0]), 32'd5);

        // Hold without grant.
        repeat (10) tick();
        #2;
        check("hold_req", 32'(o_req[0][0]), 32'd1);
        check("hold_tag", 32'(o_tag[0][0]), 32'd5);
        check("hold_not_ready", 32'(o_ready[0][0]), 32'd0);
        cdb_gnt = 2'b01;
        #2 check("gnt_comb_ready", 32'(o_ready[0][0]), 32'd1);
        tick();
        #2 check("gnt_freed", 32'(o_req[0][0]), 32'd0);

        // Back-to-back reuse on FU1.
        issue(1, 6'd7, 4'd0);
        repeat (4) tick();
        #2 check("b2b_first_done", 32'(o_req[0][1]), 32'd1);
        cdb_gnt = 2'b10;
        issue(1, 6'd9, 4'd0);
        tick();
        #2 check("b2b_no_idle", 32'(o_ready[0][1]), 32'd0);
        tick(); tick();
        #2 check("b2b_req_early", 32'(o_req[0][1]), 32'd0);
        tick();
        #2;
        check("b2b_req", 32'(o_req[0][1]), 32'd1);
        check("b2b_tag", 32'(o_tag[0][1]), 32'd9);
        cdb_gnt = 2'b10;
        tick();

        // Squash: FU0 busy on branch 0010, FU1 done on 0100.
        issue(1, 6'd3, 4'b0100);
        repeat (3) tick();
        issue(0, 6'd4, 4'b0010);
        tick();
        squash_valid = 1'b1; squash_bmask = 4'b0010;
        cdb_gnt = 2'b10;
        issue(1, 6'd11, 4'b0010);
        #2 check("squash_fu1_req", 32'(o_req[0][1]), 32'd1);
        tick();
        #2;
        check("squash_ready", 32'(o_ready[0]), 32'h3);
        check("squash_req", 32'(o_req[0]), 32'd0);

        // Resolve clears a bit; later squash on that bit misses.
        issue(0, 6'd6, 4'b0011);
        tick();
        resolve_valid = 1'b1; resolve_bmask = 4'b0001;
        #2 check("resolve_pre", 32'(o_bm[0][0]), 32'h3);
        tick();
        #2 check("resolve_post", 32'(o_bm[0][0]), 32'h2);
        squash_valid = 1'b1; squash_bmask = 4'b0001;
        tick();
        #2 check("resolve_survive", 32'(o_ready[0][0]), 32'd0);
        tick();
        #2;
        check("resolve_done", 32'(o_req[0][0]), 32'd1);
        check("resolve_done_bm", 32'(o_bm[0][0]), 32'h2);
        cdb_gnt = 2'b01;
        tick();

        // Reset mid-operation.
        issue(0, 6'd1, 4'd0);
        issue(1, 6'd2, 4'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        check("midrst_req", 32'(o_req[0]), 32'd0);
        check("midrst_ready", 32'(o_ready[0]), 32'h3);
        check("midrst_req_lat1", 32'(o_req[1]), 32'd0);

        // Random traffic.
        repeat (600) begin
            reset         = ($urandom_range(63) != 0);
            cdb_gnt       = 2'($urandom_range(3));
            squash_valid  = ($urandom_range(7) == 0);
            squash_bmask  = 4'(1 << $urandom_range(3));
            resolve_valid = ($urandom_range(5) == 0);
            resolve_bmask = 4'(1 << $urandom_range(3));
            for (int i = 0; i < 2; i++) begin
                if (exp_ready(0, i) && ($urandom_range(1) == 1))
                    issue(i, 6'($urandom), 4'($urandom));
            end
            tick();
        end
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fu_sched.md
Name: fu_sched

Overview:
- Per-FU occupancy and completion controller for a pool of fixed-latency, non-pipelined functional units, e.g. the multipliers.
- Produces the `fu_ready` vector that feeds the RS issue selector's FU request input.
- Accepts the selector's per-FU one-hot issue grants and times each FU's operation with a latency counter.
- Raises per-FU CDB requests on completion and holds the result until granted. Frees or kills FUs on CDB grant or branch squash.

Parameters:
- NUM_FU, 2, number of functional units managed.
- LAT, 4, execute latency in cycles (must be >= 1).
- TAG_W, 6, physical register tag width.
- BMASK_W, 4, branch mask width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- issue_valid  in  NUM_FU  one-hot-per-FU issue grant from the RS selector.
- issue_tag  in  NUM_FU x TAG_W  destination tag of the inst issued to each FU.
- issue_bmask  in  NUM_FU x BMASK_W  branch mask of the inst issued to each FU.
- cdb_gnt  in  NUM_FU  CDB grant per FU.
- squash_valid  in  1  branch mispredict this cycle.
- squash_bmask  in  BMASK_W  one-hot mask of the mispredicted branch.
- resolve_valid  in  1  branch correctly resolved this cycle.
- resolve_bmask  in  BMASK_W  one-hot mask of the resolved branch.
- fu_ready  out  NUM_FU  FU can accept an issue this cycle.
- num_ready  out  $clog2(NUM_FU+1)  popcount of fu_ready.
- cdb_req  out  NUM_FU  FU holds a completed result.
- cdb_tag  out  NUM_FU x TAG_W  result tag per FU.
- cdb_bmask  out  NUM_FU x BMASK_W  current branch mask of each FU's inst.

Behaviour:
- Per-FU FSM with states IDLE, BUSY, DONE, a counter of width $clog2(LAT+1), and tag/bmask registers.
- Reset: all FUs go to IDLE; counters, tags and bmasks are 0.
  - Outputs after reset: fu_ready all 1, num_ready=NUM_FU, cdb_req=0, cdb_tag=0, cdb_bmask=0.
- IDLE:
  - fu_ready[i]=1.
  - On issue_valid[i]: latch tag and bmask, with resolve bits already cleared.
  - If LAT==1, go to DONE. Otherwise go to BUSY with cnt=LAT-1.
- BUSY:
  - fu_ready[i]=0, cdb_req[i]=0.
  - If cnt==1, go to DONE; else decrement cnt.
  - cdb_req[i] first asserts exactly LAT cycles after the issue edge.
- DONE:
  - cdb_req[i]=1; cdb_tag and cdb_bmask are held stable until granted.
  - cdb_gnt[i]=1 → go to IDLE next edge.
  - No CDB grant → hold indefinitely; the FU stays unavailable.
- Same-cycle reuse:
  - fu_ready[i] = IDLE | (DONE & cdb_gnt[i]). This is a combinational path from cdb_gnt.
  - If issue_valid[i] arrives in that same DONE-and-granted cycle, the FU goes directly to BUSY (or DONE when LAT==1) with the new tag. The FU never idles a cycle.
- Illegal issue: issue_valid[i] while fu_ready[i]==0 is ignored and does not change state. The bench flags it as an assertion failure.
- Squash (highest priority):
  - If squash_valid and (stored bmask & squash_bmask) != 0, the FU goes to IDLE next edge, regardless of cdb_gnt.
  - A same-cycle issue whose issue_bmask intersects squash_bmask is dropped; the FU stays IDLE.
  - A squashed DONE FU still shows cdb_req=1 in the squash cycle. The CDB arbiter masks it using cdb_bmask.
- Resolve:
  - If resolve_valid, every stored bmask clears resolve_bmask bits at the next edge.
  - Incoming issue_bmask is also cleared before latching.
  - cdb_bmask reflects the registered (pre-clear) value in the resolve cycle.
- squash_valid and resolve_valid asserted together on different masks: both apply, squash check first.
- num_ready = combinational popcount of fu_ready.
- Reset asserted mid-operation overrides all inputs: state is forced to IDLE and in-flight results are discarded.

Test Plan:
- Reset with LAT=4, NUM_FU=2 → fu_ready=2'b11, num_ready=2, cdb_req=0. Issue FU0 tag=5 at edge t → fu_ready=2'b10 from t. cdb_req[0]=1 with cdb_tag[0]=5 in cycle t+4.
- Hold cdb_gnt=0 for 10 cycles after completion → cdb_req[0] and tag stay stable, fu_ready[0]=0. Assert cdb_gnt[0] → fu_ready[0]=1 in the same cycle, IDLE next edge.
- Back-to-back: in FU1's DONE cycle assert cdb_gnt[1] and issue_valid[1] with tag=9 → no idle gap. cdb_req[1] with tag 9 exactly 4 cycles later.
- FU0 bmask=4'b0010 BUSY, FU1 bmask=4'b0100 DONE. Squash with squash_bmask=4'b0010 → FU0 IDLE next edge, FU1 unaffected. An issue to FU1 carrying bmask 4'b0010 in the squash cycle is dropped.
- FU0 bmask=4'b0011. Resolve with resolve_bmask=4'b0001 → cdb_bmask[0]=4'b0010 next edge. A later squash on 4'b0001 does not kill FU0.
- LAT=1 build: issue at t → cdb_req at t+1. Deassert reset (drive reset=0) while both FUs are BUSY → all IDLE, cdb_req=0 next edge.
